// File: rtl/rv_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a valid/ready interface on both sides.
// Storage is a simple dual-port RAM; pointers and count alone define which entries are valid.

module rv_dpram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     wena,
    input  logic [$clog2(DEPTH)-1:0] addra,
    input  logic [WIDTH-1:0]         dina,
    input  logic                     renb,
    input  logic [$clog2(DEPTH)-1:0] addrb,
    output logic [WIDTH-1:0]         doutb
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wena) begin
            mem[addra] <= dina;
        end
    end

    // Asynchronous read, gated to zero when the read port is disabled.
    assign doutb = renb ? mem[addrb] : '0;

endmodule

module rv_sync_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [WIDTH-1:0]         s_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [WIDTH-1:0]         m_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     afull
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_write;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign afull   = (count >= CW'(AFULL_TH));
    assign s_ready = !full;
    assign m_valid = !empty;

    assign do_write = s_valid && s_ready;
    assign do_pop   = m_valid && m_ready;

    rv_dpram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .wena  (do_write),
        .addra (wr_ptr),
        .dina  (s_data),
        .renb  (!empty),
        .addrb (rd_ptr),
        .doutb (m_data)
    );

    // Pointers wrap naturally at DEPTH since it is a power of two; flush beats any handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_write && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_write) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rv_sync_fifo.sv
// Directed bench for rv_sync_fifo (DEPTH=4, AFULL_TH=3) with a queue-based reference model.

module tb_rv_sync_fifo;

    localparam int WIDTH    = 32;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [2:0]       count;
    logic             full;
    logic             empty;
    logic             afull;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] sb [$];

    rv_sync_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AFULL_TH (AFULL_TH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .afull   (afull)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against the scoreboard's view of the FIFO.
    task automatic checkOutput(input string tag);
        int n;
        n = sb.size();
        chk({tag, ".count"},   32'(count),   32'(n));
        chk({tag, ".empty"},   32'(empty),   32'(n == 0));
        chk({tag, ".full"},    32'(full),    32'(n == DEPTH));
        chk({tag, ".afull"},   32'(afull),   32'(n >= AFULL_TH));
        chk({tag, ".s_ready"}, 32'(s_ready), 32'(n != DEPTH));
        chk({tag, ".m_valid"}, 32'(m_valid), 32'(n != 0));
        chk({tag, ".m_data"},  m_data,       (n != 0) ? sb[0] : 32'h0);
    endtask

    // Drive one cycle, check pre-edge outputs, clock, then advance the model.
    task automatic applyStimulus(input string tag, input logic sv, input logic [31:0] d,
                                 input logic mr, input logic fl);
        logic wr_ok;
        logic pop_ok;
        s_valid = sv;
        s_data  = d;
        m_ready = mr;
        flush   = fl;
        #1;
        checkOutput(tag);
        wr_ok  = sv && (sb.size() < DEPTH);
        pop_ok = mr && (sb.size() > 0);
        @(posedge clk);
        if (fl) begin
            sb.delete();
        end else begin
            if (pop_ok) void'(sb.pop_front());
            if (wr_ok) sb.push_back(d);
        end
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        #12;
        checkOutput("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill then drain.
        for (int i = 0; i < 4; i++) applyStimulus("fill", 1'b1, 32'hA0 + 32'(i), 1'b0, 1'b0);
        applyStimulus("full_hold", 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus("drain", 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus("drained", 1'b0, 32'h0, 1'b0, 1'b0);

        // Write while full with a simultaneous pop is refused.
        for (int i = 0; i < 4; i++) applyStimulus("fill2", 1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
        applyStimulus("full_wr_pop", 1'b1, 32'hB4, 1'b1, 1'b0);
        applyStimulus("after_refuse", 1'b1, 32'hB5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus("drain2", 1'b0, 32'h0, 1'b1, 1'b0);

        // Concurrent write and pop at count=2, wrapping the pointers.
        applyStimulus("pre_wrap", 1'b1, 32'hC0, 1'b0, 1'b0);
        applyStimulus("pre_wrap", 1'b1, 32'hC1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus("wrap", 1'b1, 32'hC2 + 32'(i), 1'b1, 1'b0);
        applyStimulus("wrap_end", 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus("wrap_end", 1'b0, 32'h0, 1'b1, 1'b0);

        // Write-to-read latency from empty.
        applyStimulus("lat_wr", 1'b1, 32'h55, 1'b0, 1'b0);
        applyStimulus("lat_rd", 1'b0, 32'h0, 1'b1, 1'b0);

        // Flush discards the stored words and the simultaneous write.
        for (int i = 0; i < 3; i++) applyStimulus("pre_flush", 1'b1, 32'hD0 + 32'(i), 1'b0, 1'b0);
        applyStimulus("flush", 1'b1, 32'hEE, 1'b1, 1'b1);
        applyStimulus("post_flush", 1'b1, 32'h77, 1'b0, 1'b0);
        applyStimulus("head77", 1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with two entries stored.
        applyStimulus("pre_rst", 1'b1, 32'hE0, 1'b0, 1'b0);
        applyStimulus("pre_rst", 1'b1, 32'hE1, 1'b0, 1'b0);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checkOutput("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus("post_rst", 1'b1, 32'h99, 1'b0, 1'b0);
        applyStimulus("post_rst", 1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus("final", 1'b0, 32'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
